// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX pipeline register and its load-use hazard control.
package id_ex_pkg;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic reg_write;
    logic alu_src;
  } ctrl_t;

  typedef enum logic {
    IDLE   = 1'b0,
    BUBBLE = 1'b1
  } hz_state_t;

  localparam ctrl_t BUBBLE_CTRL = '0;
  localparam int    CNT_W       = 2;

endpackage : id_ex_pkg

// File: rtl/id_ex_if.sv
// Decode-side and execute-side bundle of the ID/EX register; master is the
// pipeline around the register, slave is the register itself.
interface id_ex_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int OPW  = 4
);

  logic            valid_ID;
  logic [XLEN-1:0] PC_ID, imm_ID, read_data1_ID, read_data2_ID;
  logic [REGW-1:0] rs1_ID, rs2_ID, wrin_ID;
  logic            use_rs1_ID, use_rs2_ID;
  logic [OPW-1:0]  ALUOp_ID, entrada_alu_control_ID;
  logic            Branch_ID, MemRead_ID, MemtoReg_ID, MemWrite_ID, RegWrite_ID, ALUSrc_ID;
  logic            flush, stall_ext;

  logic            valid_EX;
  logic [XLEN-1:0] PC_EX, imm_EX, read_data1_EX, read_data2_EX;
  logic [REGW-1:0] rs1_EX, rs2_EX, wrin_EX;
  logic            use_rs1_EX, use_rs2_EX;
  logic [OPW-1:0]  ALUOp_EX, entrada_alu_control_EX;
  logic            Branch_EX, MemRead_EX, MemtoReg_EX, MemWrite_EX, RegWrite_EX, ALUSrc_EX;
  logic            stall_ID;

  modport master (
    output valid_ID, PC_ID, imm_ID, read_data1_ID, read_data2_ID,
           rs1_ID, rs2_ID, wrin_ID, use_rs1_ID, use_rs2_ID,
           ALUOp_ID, entrada_alu_control_ID,
           Branch_ID, MemRead_ID, MemtoReg_ID, MemWrite_ID, RegWrite_ID, ALUSrc_ID,
           flush, stall_ext,
    input  valid_EX, PC_EX, imm_EX, read_data1_EX, read_data2_EX,
           rs1_EX, rs2_EX, wrin_EX, use_rs1_EX, use_rs2_EX,
           ALUOp_EX, entrada_alu_control_EX,
           Branch_EX, MemRead_EX, MemtoReg_EX, MemWrite_EX, RegWrite_EX, ALUSrc_EX,
           stall_ID
  );

  modport slave (
    input  valid_ID, PC_ID, imm_ID, read_data1_ID, read_data2_ID,
           rs1_ID, rs2_ID, wrin_ID, use_rs1_ID, use_rs2_ID,
           ALUOp_ID, entrada_alu_control_ID,
           Branch_ID, MemRead_ID, MemtoReg_ID, MemWrite_ID, RegWrite_ID, ALUSrc_ID,
           flush, stall_ext,
    output valid_EX, PC_EX, imm_EX, read_data1_EX, read_data2_EX,
           rs1_EX, rs2_EX, wrin_EX, use_rs1_EX, use_rs2_EX,
           ALUOp_EX, entrada_alu_control_EX,
           Branch_EX, MemRead_EX, MemtoReg_EX, MemWrite_EX, RegWrite_EX, ALUSrc_EX,
           stall_ID
  );

endinterface : id_ex_if

// File: rtl/id_ex_hz_load_use.sv
// Load-use comparator: a load in EX writes a register the ID instruction reads.
module hz_load_use #(
  parameter int REGW = 5
) (
  input  logic            valid_ex,
  input  logic            mem_read_ex,
  input  logic            reg_write_ex,
  input  logic [REGW-1:0] wrin_ex,
  input  logic            valid_id,
  input  logic            use_rs1_id,
  input  logic            use_rs2_id,
  input  logic [REGW-1:0] rs1_id,
  input  logic [REGW-1:0] rs2_id,
  output logic            hazard
);

  logic producer;
  logic consumer;

  // x0 is hardwired zero, so a load targeting it never produces a dependency.
  assign producer = valid_ex & mem_read_ex & reg_write_ex & (wrin_ex != '0);
  assign consumer = (use_rs1_id & (rs1_id == wrin_ex)) | (use_rs2_id & (rs2_id == wrin_ex));
  assign hazard   = producer & valid_id & consumer;

endmodule : hz_load_use

// File: rtl/id_ex_hz.sv
// ID/EX pipeline register with hold, flush, bubble insertion and a load-use
// stall sequencer that inserts LOAD_STALL bubbles (legal range 1..3).
module id_ex_hz
  import id_ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REGW       = 5,
  parameter int OPW        = 4,
  parameter int LOAD_STALL = 1
) (
  input logic    CLK,
  input logic    RESET_N,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] wrin;
    logic            use_rs1;
    logic            use_rs2;
  } data_t;

  data_t           data_q, data_d, id_data;
  ctrl_t           ctrl_q, ctrl_d, id_ctrl;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic [OPW-1:0]  alu_ctl_q, alu_ctl_d;
  logic            valid_q, valid_d;
  hz_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hazard;
  logic load_en;
  logic bubble_en;
  logic stall_raw;

  assign id_data = '{
    pc:      bus.PC_ID,
    imm:     bus.imm_ID,
    rd1:     bus.read_data1_ID,
    rd2:     bus.read_data2_ID,
    rs1:     bus.rs1_ID,
    rs2:     bus.rs2_ID,
    wrin:    bus.wrin_ID,
    use_rs1: bus.use_rs1_ID,
    use_rs2: bus.use_rs2_ID
  };

  assign id_ctrl = '{
    branch:     bus.Branch_ID,
    mem_read:   bus.MemRead_ID,
    mem_to_reg: bus.MemtoReg_ID,
    mem_write:  bus.MemWrite_ID,
    reg_write:  bus.RegWrite_ID,
    alu_src:    bus.ALUSrc_ID
  };

  hz_load_use #(.REGW(REGW)) u_hz (
    .valid_ex     (valid_q),
    .mem_read_ex  (ctrl_q.mem_read),
    .reg_write_ex (ctrl_q.reg_write),
    .wrin_ex      (data_q.wrin),
    .valid_id     (bus.valid_ID),
    .use_rs1_id   (bus.use_rs1_ID),
    .use_rs2_id   (bus.use_rs2_ID),
    .rs1_id       (bus.rs1_ID),
    .rs2_id       (bus.rs2_ID),
    .hazard       (hazard)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    alu_op_d  = alu_op_q;
    alu_ctl_d = alu_ctl_q;
    valid_d   = valid_q;
    load_en   = 1'b0;
    bubble_en = 1'b0;
    stall_raw = 1'b0;

    if (bus.flush) begin
      load_en   = 1'b1;
      bubble_en = 1'b1;
      state_d   = IDLE;
      cnt_d     = '0;
    end else if (bus.stall_ext) begin
      stall_raw = 1'b1;
    end else if (state_q == BUBBLE) begin
      // The producing load has already left EX, so hazard is not consulted here.
      load_en   = 1'b1;
      bubble_en = 1'b1;
      stall_raw = 1'b1;
      cnt_d     = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) state_d = IDLE;
    end else if (hazard) begin
      load_en   = 1'b1;
      bubble_en = 1'b1;
      stall_raw = 1'b1;
      if (LOAD_STALL > 1) begin
        state_d = BUBBLE;
        cnt_d   = CNT_W'(LOAD_STALL - 1);
      end
    end else begin
      load_en = 1'b1;
    end

    if (load_en) begin
      data_d = id_data;
      if (bubble_en || !bus.valid_ID) begin
        valid_d   = 1'b0;
        ctrl_d    = BUBBLE_CTRL;
        alu_op_d  = '0;
        alu_ctl_d = '0;
      end else begin
        valid_d   = 1'b1;
        ctrl_d    = id_ctrl;
        alu_op_d  = bus.ALUOp_ID;
        alu_ctl_d = bus.entrada_alu_control_ID;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!RESET_N) begin
      data_q    <= '0;
      ctrl_q    <= BUBBLE_CTRL;
      alu_op_q  <= '0;
      alu_ctl_q <= '0;
      valid_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
    end else begin
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      alu_ctl_q <= alu_ctl_d;
      valid_q   <= valid_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  // Gated by reset so a pending stall_ext cannot freeze fetch while in reset.
  assign bus.stall_ID = stall_raw & RESET_N;

  assign bus.valid_EX               = valid_q;
  assign bus.PC_EX                  = data_q.pc;
  assign bus.imm_EX                 = data_q.imm;
  assign bus.read_data1_EX          = data_q.rd1;
  assign bus.read_data2_EX          = data_q.rd2;
  assign bus.rs1_EX                 = data_q.rs1;
  assign bus.rs2_EX                 = data_q.rs2;
  assign bus.wrin_EX                = data_q.wrin;
  assign bus.use_rs1_EX             = data_q.use_rs1;
  assign bus.use_rs2_EX             = data_q.use_rs2;
  assign bus.ALUOp_EX               = alu_op_q;
  assign bus.entrada_alu_control_EX = alu_ctl_q;
  assign bus.Branch_EX              = ctrl_q.branch;
  assign bus.MemRead_EX             = ctrl_q.mem_read;
  assign bus.MemtoReg_EX            = ctrl_q.mem_to_reg;
  assign bus.MemWrite_EX            = ctrl_q.mem_write;
  assign bus.RegWrite_EX            = ctrl_q.reg_write;
  assign bus.ALUSrc_EX              = ctrl_q.alu_src;

endmodule : id_ex_hz

// File: tb/tb_id_ex_hz.sv
// Bench for id_ex_hz: three instances (LOAD_STALL 1..3) share one ID stream and
// are compared every cycle against a remaining-bubbles reference model.
module tb_id_ex_hz;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, imm, rd1, rd2;
    logic [4:0]  rs1, rs2, wrin;
    logic        use1, use2;
    logic [3:0]  aluop, aluctl;
    logic        br, mr, m2r, mw, rw, asrc;
  } id_rec_t;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    flush, stall_ext;
  id_rec_t id_in;
  id_rec_t ex_out [3];
  logic    stall_out [3];

  id_rec_t exp_ex [3];
  int      rem [3];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    id_ex_if #(.XLEN(32), .REGW(5), .OPW(4)) ifc ();

    id_ex_hz #(.XLEN(32), .REGW(5), .OPW(4), .LOAD_STALL(g + 1)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (ifc)
    );

    assign ifc.valid_ID               = id_in.valid;
    assign ifc.PC_ID                  = id_in.pc;
    assign ifc.imm_ID                 = id_in.imm;
    assign ifc.read_data1_ID          = id_in.rd1;
    assign ifc.read_data2_ID          = id_in.rd2;
    assign ifc.rs1_ID                 = id_in.rs1;
    assign ifc.rs2_ID                 = id_in.rs2;
    assign ifc.wrin_ID                = id_in.wrin;
    assign ifc.use_rs1_ID             = id_in.use1;
    assign ifc.use_rs2_ID             = id_in.use2;
    assign ifc.ALUOp_ID               = id_in.aluop;
    assign ifc.entrada_alu_control_ID = id_in.aluctl;
    assign ifc.Branch_ID              = id_in.br;
    assign ifc.MemRead_ID             = id_in.mr;
    assign ifc.MemtoReg_ID            = id_in.m2r;
    assign ifc.MemWrite_ID            = id_in.mw;
    assign ifc.RegWrite_ID            = id_in.rw;
    assign ifc.ALUSrc_ID              = id_in.asrc;
    assign ifc.flush                  = flush;
    assign ifc.stall_ext              = stall_ext;

    assign ex_out[g] = '{
      valid: ifc.valid_EX, pc: ifc.PC_EX, imm: ifc.imm_EX,
      rd1: ifc.read_data1_EX, rd2: ifc.read_data2_EX,
      rs1: ifc.rs1_EX, rs2: ifc.rs2_EX, wrin: ifc.wrin_EX,
      use1: ifc.use_rs1_EX, use2: ifc.use_rs2_EX,
      aluop: ifc.ALUOp_EX, aluctl: ifc.entrada_alu_control_EX,
      br: ifc.Branch_EX, mr: ifc.MemRead_EX, m2r: ifc.MemtoReg_EX,
      mw: ifc.MemWrite_EX, rw: ifc.RegWrite_EX, asrc: ifc.ALUSrc_EX
    };
    assign stall_out[g] = ifc.stall_ID;
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic id_rec_t bubble_of(id_rec_t r);
    id_rec_t b = r;
    b.valid = 1'b0; b.aluop = '0; b.aluctl = '0;
    b.br = 1'b0; b.mr = 1'b0; b.m2r = 1'b0; b.mw = 1'b0; b.rw = 1'b0; b.asrc = 1'b0;
    return b;
  endfunction

  function automatic logic load_use(id_rec_t ex, id_rec_t id);
    if (!(ex.valid && ex.mr && ex.rw && ex.wrin != 0 && id.valid)) return 1'b0;
    return (id.use1 && id.rs1 == ex.wrin) || (id.use2 && id.rs2 == ex.wrin);
  endfunction

  function automatic logic exp_stall(int k);
    if (!rst_n || flush) return 1'b0;
    if (stall_ext || rem[k] > 0) return 1'b1;
    return load_use(exp_ex[k], id_in);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        exp_ex[k] = '0;
        rem[k]    = 0;
      end else if (flush) begin
        exp_ex[k] = bubble_of(id_in);
        rem[k]    = 0;
      end else if (stall_ext) begin
        // frozen
      end else if (rem[k] > 0) begin
        exp_ex[k] = bubble_of(id_in);
        rem[k]    = rem[k] - 1;
      end else if (load_use(exp_ex[k], id_in)) begin
        exp_ex[k] = bubble_of(id_in);
        rem[k]    = k;            // LOAD_STALL-1 more bubbles still owed
      end else begin
        exp_ex[k] = id_in.valid ? id_in : bubble_of(id_in);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ex_ls%0d", k + 1), ex_out[k], exp_ex[k]);
      check($sformatf("stall_ls%0d", k + 1), stall_out[k], exp_stall(k));
    end
  end

  // ---------------- stimulus ----------------
  function automatic id_rec_t mk(logic [31:0] pc, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                                 logic u2, logic [4:0] wrin, logic mr, logic rw);
    id_rec_t r;
    r = '0;
    r.valid = 1'b1; r.pc = pc; r.imm = pc ^ 32'h1000; r.rd1 = 32'hA0A0_0000 | pc; r.rd2 = ~pc;
    r.rs1 = rs1; r.use1 = u1; r.rs2 = rs2; r.use2 = u2; r.wrin = wrin;
    r.aluop = 4'h2; r.aluctl = 4'h6; r.mr = mr; r.m2r = mr; r.asrc = mr; r.rw = rw;
    return r;
  endfunction

  function automatic id_rec_t rnd();
    id_rec_t r;
    r.valid = ($urandom_range(0, 7) != 0);
    r.pc = $urandom; r.imm = $urandom; r.rd1 = $urandom; r.rd2 = $urandom;
    r.rs1 = 5'($urandom_range(0, 3)); r.rs2 = 5'($urandom_range(0, 3));
    r.wrin = 5'($urandom_range(0, 3));
    r.use1 = 1'($urandom); r.use2 = 1'($urandom);
    r.aluop = 4'($urandom); r.aluctl = 4'($urandom);
    r.br = 1'($urandom); r.mr = 1'($urandom); r.m2r = 1'($urandom);
    r.mw = 1'($urandom); r.rw = ($urandom_range(0, 3) != 0); r.asrc = 1'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  id_rec_t lw5, add5;
  int st [3];
  int bub2;
  logic ext_now;

  initial begin
    rst_n = 1'b1; flush = 1'b0; stall_ext = 1'b0; id_in = '0;
    lw5  = mk(32'h44, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    add5 = mk(32'h48, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check("rst_ex", ex_out[0], 192'd0);
    check("rst_stall", stall_out[0], 1'b0);
    tick();

    // normal load
    id_in = mk(32'h40, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1);
    tick();
    check("norm_pc", ex_out[0].pc, 32'h40);
    check("norm_rw", ex_out[0].rw, 1'b1);
    check("norm_valid", ex_out[0].valid, 1'b1);
    #1 check("norm_stall", stall_out[0], 1'b0);

    // load-use, all three depths at once
    id_in = lw5; tick();
    id_in = add5;
    for (int k = 0; k < 3; k++) st[k] = 0;
    bub2 = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      for (int k = 0; k < 3; k++) st[k] += int'(stall_out[k]);
      tick();
      if (i == 0) check("lu1_bubble", {ex_out[0].valid, ex_out[0].rw}, 2'b00);
      if (i == 1) check("lu1_add", {ex_out[0].valid, ex_out[0].pc}, {1'b1, 32'h48});
      bub2 += int'(!ex_out[2].valid);
    end
    check("lu1_stalls", st[0], 1);
    check("lu2_stalls", st[1], 2);
    check("lu3_stalls", st[2], 3);
    check("lu3_bubbles", bub2, 3);
    check("lu3_add", {ex_out[2].valid, ex_out[2].pc}, {1'b1, 32'h48});

    // LOAD_STALL=3 with a 2-cycle external stall in the middle
    id_in = lw5; tick();
    id_in = add5;
    st[2] = 0; bub2 = 0;
    for (int i = 0; i < 7; i++) begin
      stall_ext = (i == 1 || i == 2);
      ext_now = stall_ext;
      #1 st[2] += int'(stall_out[2]);
      tick();
      if (!ext_now && !ex_out[2].valid) bub2++;
    end
    stall_ext = 1'b0;
    check("ext_stalls", st[2], 5);
    check("ext_bubbles", bub2, 3);

    // x0 destination and unused rs2
    id_in = mk(32'h50, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); tick();
    id_in = mk(32'h54, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1);
    #1 check("x0_ls1", stall_out[0], 1'b0);
    check("x0_ls3", stall_out[2], 1'b0);
    tick();
    id_in = mk(32'h58, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); tick();
    id_in = mk(32'h5c, 5'd1, 1'b1, 5'd5, 1'b0, 5'd8, 1'b0, 1'b1);
    #1 check("unused_rs2", stall_out[0], 1'b0);
    tick();

    // flush together with a hazard
    id_in = lw5; tick();
    id_in = add5; flush = 1'b1;
    #1 check("flush_hz_stall", stall_out[0], 1'b0);
    tick();
    flush = 1'b0;
    check("flush_hz_bubble", ex_out[0].valid, 1'b0);
    #1 check("flush_hz_idle", stall_out[1], 1'b0);
    tick();
    check("flush_hz_add", {ex_out[1].valid, ex_out[1].pc}, {1'b1, 32'h48});

    // flush while LOAD_STALL=2 sits in BUBBLE
    id_in = lw5; tick();
    id_in = add5;
    #1 check("flushb_hz", stall_out[1], 1'b1);
    tick();
    flush = 1'b1;
    #1 check("flushb_stall", stall_out[1], 1'b0);
    tick();
    flush = 1'b0;
    check("flushb_bubble", ex_out[1].valid, 1'b0);
    #1 check("flushb_idle", stall_out[1], 1'b0);
    tick();
    check("flushb_add", ex_out[1].valid, 1'b1);

    // asynchronous reset in the middle of LOAD_STALL=3 bubbles
    id_in = lw5; tick();
    id_in = add5; tick();
    #1 rst_n = 1'b0;
    #1 check("rstb_ex", ex_out[2], 192'd0);
    check("rstb_stall", stall_out[2], 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("rstb_rel_stall", stall_out[2], 1'b0);
    id_in = mk(32'h80, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1);
    tick();
    check("rstb_first", {ex_out[2].valid, ex_out[2].pc}, {1'b1, 32'h80});

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) id_in = rnd();
      flush     = ($urandom_range(0, 15) == 0);
      stall_ext = ($urandom_range(0, 7) == 0);
      tick();
    end
    flush = 1'b0; stall_ext = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_id_ex_hz

// File: doc/id_ex_hz.md
Name: id_ex_hz

Overview:
Parametrised ID/EX pipeline register for the segmented RISC-V core. It adds hold, flush and bubble insertion, plus a per-instruction valid bit. It includes load-use hazard detection with a configurable number of stall cycles. It sits between decode and execute and drives stall_ID to the PC and IF/ID registers.

Parameters:
XLEN, 32, datapath width (PC, immediate, operands)
REGW, 5, register index width
OPW, 4, width of ALUOp and entrada_alu_control
LOAD_STALL, 1, bubbles inserted per load-use hazard; legal range 1..3

Ports:
CLK  in  1  clock
RESET_N  in  1  async active-low reset
valid_ID  in  1  ID holds a real instruction
PC_ID, imm_ID, read_data1_ID, read_data2_ID  in  XLEN  decode datapath fields
rs1_ID, rs2_ID, wrin_ID  in  REGW  source and destination register indices
use_rs1_ID, use_rs2_ID  in  1  instruction actually reads rs1 / rs2
ALUOp_ID, entrada_alu_control_ID  in  OPW  ALU control
Branch_ID, MemRead_ID, MemtoReg_ID, MemWrite_ID, RegWrite_ID, ALUSrc_ID  in  1  control bits
flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
stall_ext  in  1  downstream (memory) stall; freeze the stage
*_EX  out  same widths  registered copies of all *_ID fields above, including rs1_EX, rs2_EX, valid_EX
stall_ID  out  1  hold PC and IF/ID this cycle (combinational)

Behaviour:
- Reset: RESET_N is asynchronous and active-low; the clock is CLK. All *_EX outputs clear to 0, the FSM goes to IDLE and cnt clears to 0. stall_ID is 0 while in reset.
- Latency: 1 cycle from ID to EX on normal load.
- Hazard (combinational), true when all of the following hold:
  - valid_EX & MemRead_EX & RegWrite_EX
  - wrin_EX != 0
  - valid_ID
  - (use_rs1_ID & rs1_ID == wrin_EX) | (use_rs2_ID & rs2_ID == wrin_EX)
- Bubble: valid_EX, Branch, MemRead, MemtoReg, MemWrite, RegWrite, ALUSrc, ALUOp_EX and entrada_alu_control_EX are all loaded as 0. Data and index fields are loaded from ID normally and are don't-care.
- valid_ID=0 on a normal load behaves as a bubble: control fields are forced to 0.
- FSM states: IDLE, BUBBLE. cnt is 2 bits.
- Per-cycle priority:
  1. flush: load bubble; state to IDLE; cnt to 0; stall_ID=0. Flush overrides hazard and stall_ext.
  2. stall_ext: all registers, state and cnt hold; stall_ID=1.
  3. IDLE with hazard: load bubble; stall_ID=1. If LOAD_STALL>1, go to BUBBLE with cnt=LOAD_STALL-1; otherwise stay in IDLE.
  4. BUBBLE: load bubble; stall_ID=1; cnt decrements. When cnt==1, go to IDLE.
  5. Otherwise: normal load from ID; stall_ID=0.
- Total stall_ID cycles per hazard = LOAD_STALL, excluding stall_ext cycles.
- In BUBBLE, hazard is not re-evaluated: the producing load has left EX.
- After BUBBLE returns to IDLE, the held ID instruction loads on the next unstalled cycle.
- Back-to-back hazards: a new hazard against the newly loaded instruction is detected normally.
- Reset asserted mid-BUBBLE: immediate clear. No residual stall after release.

Decomposition:
- Package id_ex_pkg:
  - ctrl_t packed struct {Branch, MemRead, MemtoReg, MemWrite, RegWrite, ALUSrc}
  - hz_state_t enum {IDLE, BUBBLE}
  - BUBBLE_CTRL constant (all zeros)
- Sub-module hz_load_use: the combinational hazard comparator, reusable by a later forwarding unit.
- Everything else is inline.

Test Plan:
- Normal: valid_ID=1, PC_ID=0x40, RegWrite_ID=1, wrin_ID=5, no hazard. Next cycle: PC_EX=0x40, RegWrite_EX=1, valid_EX=1, stall_ID=0.
- Load-use, LOAD_STALL=1: EX holds lw x5 (MemRead_EX=1, wrin_EX=5); ID has add with rs1=5, use_rs1=1.
  - stall_ID=1 for exactly 1 cycle; EX gets a bubble (valid_EX=0, RegWrite_EX=0).
  - Next cycle the add loads with valid_EX=1.
- LOAD_STALL=3, same stimulus: stall_ID=1 for 3 consecutive cycles, 3 bubbles, then the add enters EX. Repeat with stall_ext=1 for 2 cycles mid-sequence: 5 stall cycles total, bubble count still 3.
- x0 and unused operand:
  - lw x0 followed by a use of rs1=0: no stall.
  - lw x5 followed by rs2=5 with use_rs2=0: no stall.
- Flush priority: hazard and flush asserted together, and separately flush during BUBBLE with LOAD_STALL=2. In both cases stall_ID=0 that cycle, EX gets a bubble, and the FSM returns to IDLE.
- Reset: RESET_N pulled low mid-BUBBLE, asynchronously between clock edges. All outputs are 0 immediately; after release stall_ID=0 and the first valid instruction passes in 1 cycle.
